// File: rtl/l2_resp_tracker_pkg.sv
// Shared types and constants for the L2 bank response tracker.
// The tag is what follows a granted access down the SRAM-latency delay line.
package l2_resp_tracker_pkg;

  localparam int L2_MAX_MEM_LATENCY = 8;
  localparam int L2_TAG_ID_W        = 8;

  function automatic int l2_id_width(input int n_master);
    return (n_master > 2) ? $clog2(n_master) : 1;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [L2_TAG_ID_W-1:0] id;
    logic                   we;
  } l2_resp_tag_t;

endpackage

// File: rtl/l2_resp_tracker_if.sv
// Grant side (from the bank arbiter and SRAM) and response side (to the fan-in tree)
// of one L2 bank.
interface l2_resp_tracker_if
  import l2_resp_tracker_pkg::*;
#(
  parameter int N_MASTER   = 4,
  parameter int ID_WIDTH   = l2_id_width(N_MASTER),
  parameter int DATA_WIDTH = 64
);

  logic                  gnt_i;
  logic [ID_WIDTH-1:0]   gnt_id_i;
  logic                  gnt_we_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [N_MASTER-1:0]   resp_valid_o;
  logic [DATA_WIDTH-1:0] resp_rdata_o;
  logic                  busy_o;
  logic                  err_o;

  modport slave (
    input  gnt_i, gnt_id_i, gnt_we_i, mem_rdata_i,
    output resp_valid_o, resp_rdata_o, busy_o, err_o
  );

  modport master (
    output gnt_i, gnt_id_i, gnt_we_i, mem_rdata_i,
    input  resp_valid_o, resp_rdata_o, busy_o, err_o
  );

endinterface

// File: rtl/l2_resp_tracker_delay_line.sv
// Fixed-depth shift register carrying grant tags until SRAM read data is due.
// Only the valid bits are reset; id/we are payload that is ignored while invalid.
module l2_resp_tracker_delay_line
  import l2_resp_tracker_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  l2_resp_tag_t     tag_i,
  output l2_resp_tag_t     tag_o,
  output logic [DEPTH-1:0] vld_o
);

  logic [DEPTH-1:0]       vld_q;
  logic [L2_TAG_ID_W-1:0] id_q [DEPTH];
  logic [DEPTH-1:0]       we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= tag_i.valid;
      for (int s = 1; s < DEPTH; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  // Payload only moves behind a valid bit, so idle grant-side X never enters the line.
  always_ff @(posedge clk) begin
    if (tag_i.valid) begin
      id_q[0] <= tag_i.id;
      we_q[0] <= tag_i.we;
    end
    for (int s = 1; s < DEPTH; s++) begin
      if (vld_q[s-1]) begin
        id_q[s] <= id_q[s-1];
        we_q[s] <= we_q[s-1];
      end
    end
  end

  always_comb begin
    tag_o.valid = vld_q[DEPTH-1];
    tag_o.id    = id_q[DEPTH-1];
    tag_o.we    = we_q[DEPTH-1];
  end

  assign vld_o = vld_q;

endmodule

// File: rtl/l2_resp_tracker.sv
// Per-bank response generator: delays the granted master's tag by the SRAM latency and
// presents a one-hot valid with shared read data to the response fan-in tree.
module l2_resp_tracker
  import l2_resp_tracker_pkg::*;
#(
  parameter int N_MASTER    = 4,
  parameter int ID_WIDTH    = l2_id_width(N_MASTER),
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 1,
  parameter int REG_RDATA   = 0
) (
  input logic              clk,
  input logic              rst_n,
  l2_resp_tracker_if.slave bus
);

  localparam int DEPTH = (MEM_LATENCY < 1) ? 1 :
                         (MEM_LATENCY > L2_MAX_MEM_LATENCY) ? L2_MAX_MEM_LATENCY : MEM_LATENCY;
  localparam logic [ID_WIDTH:0] ID_LIMIT = (ID_WIDTH+1)'(N_MASTER);

  logic [ID_WIDTH-1:0]   gnt_id_m;
  logic                  id_ok;
  l2_resp_tag_t          tag_in;
  l2_resp_tag_t          tag_out;
  logic [DEPTH-1:0]      line_vld;
  logic                  err_q;
  logic [N_MASTER-1:0]   resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_d;

  // Grant capture: out-of-range ids are dropped here and reported one cycle later.
  assign gnt_id_m = bus.gnt_i ? bus.gnt_id_i : '0;
  assign id_ok    = ({1'b0, gnt_id_m} < ID_LIMIT);

  always_comb begin
    tag_in.valid = bus.gnt_i & id_ok;
    tag_in.id    = L2_TAG_ID_W'(gnt_id_m);
    tag_in.we    = bus.gnt_i & bus.gnt_we_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= bus.gnt_i & ~id_ok;
    end
  end

  assign bus.err_o = err_q;

  l2_resp_tracker_delay_line #(
    .DEPTH (DEPTH)
  ) u_delay_line (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out),
    .vld_o (line_vld)
  );

  // Last stage of the line lines up with SRAM rdata: decode the owner, zero data on writes.
  always_comb begin
    resp_valid_d = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      resp_valid_d[k] = tag_out.valid && (tag_out.id == L2_TAG_ID_W'(k));
    end
    resp_rdata_d = (tag_out.valid && !tag_out.we) ? bus.mem_rdata_i : '0;
  end

  if (REG_RDATA != 0) begin : g_reg_out
    logic [N_MASTER-1:0]   resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        resp_valid_q <= '0;
      end else begin
        resp_valid_q <= resp_valid_d;
      end
    end

    always_ff @(posedge clk) begin
      resp_rdata_q <= resp_rdata_d;
    end

    // Data register is unreset; gating by the registered valid keeps reset output at zero.
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_rdata_o = (|resp_valid_q) ? resp_rdata_q : '0;
    assign bus.busy_o       = (|line_vld) | (|resp_valid_q);
  end else begin : g_comb_out
    assign bus.resp_valid_o = resp_valid_d;
    assign bus.resp_rdata_o = resp_rdata_d;
    assign bus.busy_o       = |line_vld;
  end

endmodule
